// File: rtl/uart_tx_if.sv
// uart_tx_if: valid/ready byte write port into the UART transmitter FIFO
interface uart_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx.sv
// uart_tx: FIFO-buffered 8N1 UART transmitter with runtime baud divider
module uart_tx #(
    parameter int FIFO_DEPTH = 4,
    parameter int DATA_BITS  = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] baud_div,
    uart_tx_if.slave    wr,
    output logic        TX,
    output logic        tx_busy,
    output logic        tx_done
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t                 state_q, state_d;
    logic [DATA_BITS-1:0]   mem_q [FIFO_DEPTH];
    logic [DATA_BITS-1:0]   mem_d [FIFO_DEPTH];
    logic [AW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]            count_q, count_d;
    logic [15:0]            cnt_q, cnt_d, period_q, period_d;
    logic [2:0]             bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   tx_q, tx_d, busy_q, busy_d, done_q, done_d;
    logic                   push, pop, last, fifo_empty;

    // Count never exceeds the power-of-2 depth, so its MSB alone flags full
    assign fifo_empty  = (count_q == '0);
    assign wr.tx_ready = !count_q[AW];
    assign push        = wr.tx_valid && wr.tx_ready;
    assign last        = (cnt_q == period_q - 16'd1);
    assign pop         = !fifo_empty && (state_q == IDLE || (state_q == STOP && last));
    assign TX          = tx_q;
    assign tx_busy     = busy_q;
    assign tx_done     = done_q;

    // Next-state: FIFO bookkeeping, bit timing and frame sequencing; a pop restarts a frame
    always_comb begin
        state_d   = state_q;
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        cnt_d     = (state_q == IDLE) ? cnt_q : (last ? '0 : cnt_q + 16'd1);
        period_d  = period_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        if (push) begin
            mem_d[wr_ptr_q] = wr.tx_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        case (state_q)
            START: if (last) begin
                state_d   = DATA;
                bit_idx_d = '0;
            end
            DATA: if (last) begin
                shift_d   = shift_q >> 1;
                bit_idx_d = bit_idx_q + 3'd1;
                state_d   = (bit_idx_q == 3'(DATA_BITS - 1)) ? STOP : DATA;
            end
            STOP: if (last) state_d = IDLE;
            default: ;
        endcase
        if (pop) begin
            shift_d  = mem_q[rd_ptr_q];
            rd_ptr_d = rd_ptr_q + 1'b1;
            period_d = (baud_div < 16'd2) ? 16'd2 : baud_div;
            cnt_d    = '0;
            state_d  = START;
        end
        count_d = count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        tx_d    = (state_q == START) ? 1'b0 : (state_q == DATA) ? shift_q[0] : 1'b1;
        done_d  = (state_q == STOP) && last;
        busy_d  = (state_q != IDLE) || !fifo_empty;
    end

    // State and registered outputs; the line level lags the state by one cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            cnt_q     <= '0;
            period_q  <= 16'd2;
            bit_idx_q <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            mem_q     <= mem_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            cnt_q     <= cnt_d;
            period_q  <= period_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: scoreboard bench; a serial monitor decodes TX frames against queued expectations
module tb_uart_tx;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] baud_div = 16'd233;
    logic        TX, tx_busy, tx_done;
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          done_cnt = 0;
    int          last_end = -100;
    bit          mon_en = 1'b1;
    logic        prev_tx = 1'b1;

    typedef struct {
        logic [7:0] b;
        int         p;
        bit         b2b;
    } exp_t;

    exp_t sb[$];

    uart_tx_if bus ();

    uart_tx #(.FIFO_DEPTH(4), .DATA_BITS(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .baud_div(baud_div),
        .wr      (bus.slave),
        .TX      (TX),
        .tx_busy (tx_busy),
        .tx_done (tx_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) if (tx_done === 1'b1) done_cnt <= done_cnt + 1;

    task automatic check(input bit ok, input string name, input int act, input int exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cyc);
        end
    endtask

    task automatic put(input logic [7:0] b, input int p, input bit b2b, input bit track);
        bus.tx_data  = b;
        bus.tx_valid = 1'b1;
        if (track) sb.push_back('{b: b, p: p, b2b: b2b});
        @(posedge clk);
        #1;
        bus.tx_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (tx_busy !== 1'b0 && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(tx_busy === 1'b0, "idle_timeout", n, budget);
        repeat (4) @(posedge clk);
        #1;
    endtask

    // Serial receiver model: finds each start edge, samples mid-bit and checks framing and timing
    initial begin : monitor
        exp_t       e;
        logic [7:0] got;
        int         t0;
        forever begin
            @(negedge clk);
            if (mon_en && prev_tx === 1'b1 && TX === 1'b0) begin
                if (sb.size() == 0) begin
                    check(1'b0, "unexpected_frame", 1, 0);
                end else begin
                    e  = sb.pop_front();
                    t0 = cyc;
                    if (e.b2b) check(t0 == last_end + 1, "b2b_gap", t0 - last_end - 1, 0);
                    repeat (e.p / 2) @(negedge clk);
                    check(TX === 1'b0, "start_bit", int'(TX), 0);
                    for (int k = 0; k < 8; k++) begin
                        repeat (e.p) @(negedge clk);
                        got[k] = TX;
                    end
                    repeat (e.p) @(negedge clk);
                    check(TX === 1'b1, "stop_bit", int'(TX), 1);
                    repeat (e.p - e.p / 2 - 1) @(negedge clk);
                    check(tx_done === 1'b1, "done_at_frame_end", int'(tx_done), 1);
                    last_end = cyc;
                    check(got === e.b, "rx_byte", int'(got), int'(e.b));
                end
            end
            prev_tx = TX;
        end
    end

    initial begin : stim
        int  i;
        logic rdy;
        bit  full_seen;
        bus.tx_data  = 8'h00;
        bus.tx_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check(TX === 1'b1, "reset_tx", int'(TX), 1);
        check(tx_busy === 1'b0, "reset_busy", int'(tx_busy), 0);
        check(tx_done === 1'b0, "reset_done", int'(tx_done), 0);
        check(bus.tx_ready === 1'b1, "reset_ready", int'(bus.tx_ready), 1);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Single 0x55 frame: latency, busy and done timing
        put(8'h55, 233, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        check(TX === 1'b1, "latency_n1_high", int'(TX), 1);
        @(posedge clk);
        #1;
        check(TX === 1'b0, "latency_n2_low", int'(TX), 0);
        check(tx_busy === 1'b1, "busy_in_frame", int'(tx_busy), 1);
        repeat (2329) @(posedge clk);
        #1;
        check(tx_busy === 1'b1, "busy_last_cycle", int'(tx_busy), 1);
        check(tx_done === 1'b1, "done_pulse", int'(tx_done), 1);
        @(posedge clk);
        #1;
        check(tx_busy === 1'b0, "busy_falls", int'(tx_busy), 0);
        check(tx_done === 1'b0, "done_one_cycle", int'(tx_done), 0);
        check(TX === 1'b1, "tx_idle_high", int'(TX), 1);
        wait_idle(100);

        // Back-to-back 0x55, 0xAA
        put(8'h55, 233, 1'b0, 1'b1);
        put(8'hAA, 233, 1'b1, 1'b1);
        wait_idle(6000);

        // Six bytes with tx_valid held; FIFO fills and 0x06 waits
        baud_div  = 16'd4;
        i         = 1;
        full_seen = 1'b0;
        for (int n = 0; i <= 6 && n < 2000; n++) begin
            if (i == 6 && !full_seen) begin
                check(bus.tx_ready === 1'b0, "fifo_full_ready", int'(bus.tx_ready), 0);
                full_seen = 1'b1;
            end
            bus.tx_data  = 8'(i);
            bus.tx_valid = 1'b1;
            rdy          = bus.tx_ready;
            @(posedge clk);
            #1;
            if (rdy) begin
                sb.push_back('{b: 8'(i), p: 4, b2b: (i != 1)});
                i++;
            end
        end
        bus.tx_valid = 1'b0;
        check(i == 7, "fill_timeout", i, 7);
        wait_idle(1000);

        // Baud change mid-frame applies to the next frame only
        baud_div = 16'd233;
        put(8'hA5, 233, 1'b0, 1'b1);
        put(8'h3C, 100, 1'b1, 1'b1);
        repeat (500) @(posedge clk);
        #1;
        baud_div = 16'd100;
        wait_idle(5000);

        // Reset during data bit 3 with two bytes queued
        mon_en   = 1'b0;
        baud_div = 16'd8;
        put(8'h11, 8, 1'b0, 1'b0);
        put(8'h22, 8, 1'b0, 1'b0);
        put(8'h33, 8, 1'b0, 1'b0);
        repeat (34) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check(TX === 1'b1, "abort_tx", int'(TX), 1);
        check(tx_busy === 1'b0, "abort_busy", int'(tx_busy), 0);
        check(bus.tx_ready === 1'b1, "abort_ready", int'(bus.tx_ready), 1);
        mon_en = 1'b1;
        repeat (300) @(posedge clk);
        #1;
        check(tx_busy === 1'b0, "abort_no_frames", int'(tx_busy), 0);

        // Clamped divider: baud_div 0 and 1 give P=2
        baud_div = 16'd0;
        put(8'h96, 2, 1'b0, 1'b1);
        wait_idle(100);
        baud_div = 16'd1;
        put(8'h69, 2, 1'b0, 1'b1);
        wait_idle(100);

        repeat (10) @(posedge clk);
        #1;
        check(sb.size() == 0, "frames_missing", sb.size(), 0);
        check(done_cnt == 13, "done_count", done_cnt, 13);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "timeout");
    end
endmodule
